// File: rtl/comb_sweep_ctrl_if.sv
// comb_sweep_ctrl_if: signal bundle between the sweep controller and its environment
//   master: controller side; drives drv_in, busy, done, cap_valid, cap_code, cap_data, sig
//   slave : environment side (host, block under test, logger); drives start, hold, dut_out
//   start/hold : host sweep request and pause
//   dut_out    : 5 outputs of the combinational block, [4]=out1 .. [0]=out5
//   drv_in     : 4 inputs of the combinational block, [3]=in1 .. [0]=in4
//   busy/done  : sweep handshake toward the host
//   cap_*      : per-code capture strobe toward a logger
//   sig        : running 8-bit signature
//   SWEEP_CHECK_EN adds err_flag/err_cnt from the built-in golden check
interface comb_sweep_ctrl_if;
    logic       start;
    logic       hold;
    logic [4:0] dut_out;
    logic [3:0] drv_in;
    logic       busy;
    logic       done;
    logic       cap_valid;
    logic [3:0] cap_code;
    logic [4:0] cap_data;
    logic [7:0] sig;
`ifdef SWEEP_CHECK_EN
    logic       err_flag;
    logic [4:0] err_cnt;
`endif
    modport master (
        input  start, hold, dut_out,
        output drv_in, busy, done, cap_valid, cap_code, cap_data, sig
`ifdef SWEEP_CHECK_EN
        , output err_flag, err_cnt
`endif
    );
    modport slave (
        output start, hold, dut_out,
        input  drv_in, busy, done, cap_valid, cap_code, cap_data, sig
`ifdef SWEEP_CHECK_EN
        , input err_flag, err_cnt
`endif
    );
endinterface

// File: rtl/comb_sweep_ctrl.sv
// comb_sweep_ctrl: sweeps a 4-in/5-out combinational block through codes FIRST..LAST and signs its outputs
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_io : comb_sweep_ctrl_if.master (start, hold, dut_out in; drv_in, busy, done, cap_*, sig out)
//   SETTLE : cycles each code is held before capture (1..255)
//   FIRST/LAST : inclusive code range of the sweep
//   Optional macro SWEEP_CHECK_EN: compares each capture with a built-in golden model
//   and reports err_flag (sticky) / err_cnt (saturating at 31).
module comb_sweep_ctrl #(
    parameter int unsigned SETTLE = 2,
    parameter logic [3:0]  FIRST  = 4'd0,
    parameter logic [3:0]  LAST   = 4'd15
) (
    input  logic              clk,
    input  logic              rst_n,
    comb_sweep_ctrl_if.master bus_io
);
    localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);
    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;
    state_t     state_q;
    logic [7:0] cnt_q;
    logic [3:0] drv_q;
    logic [3:0] code_q;
    logic [4:0] data_q;
    logic [7:0] sig_q;
    logic [7:0] sig_d;
    logic       busy_q;
    logic       done_q;
    logic       valid_q;
    // rotate-left then fold in the captured outputs
    assign sig_d = {sig_q[6:0], sig_q[7]} ^ {3'b000, bus_io.dut_out};
`ifdef SWEEP_CHECK_EN
    logic [4:0] exp_d;
    logic       err_flag_q;
    logic [4:0] err_cnt_q;
    assign exp_d = {drv_q[3] | (drv_q[2] & drv_q[1]),
                    (~drv_q[3] & ~drv_q[1]) | (~drv_q[3] & ~drv_q[2]) | (&drv_q[3:1]),
                    drv_q[2] ^ drv_q[1],
                    ~drv_q[1],
                    drv_q[0]};
    assign bus_io.err_flag = err_flag_q;
    assign bus_io.err_cnt  = err_cnt_q;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drv_q   <= '0;
            code_q  <= '0;
            data_q  <= '0;
            sig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef SWEEP_CHECK_EN
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: if (bus_io.start) begin
                    drv_q   <= FIRST;
                    cnt_q   <= '0;
                    sig_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= DRIVE;
`ifdef SWEEP_CHECK_EN
                    err_flag_q <= 1'b0;
                    err_cnt_q  <= '0;
`endif
                end
                DRIVE: if (!bus_io.hold) begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    data_q  <= bus_io.dut_out;
                    code_q  <= drv_q;
                    valid_q <= 1'b1;
                    sig_q   <= sig_d;
`ifdef SWEEP_CHECK_EN
                    if (bus_io.dut_out != exp_d) begin
                        err_flag_q <= 1'b1;
                        if (err_cnt_q != 5'd31) err_cnt_q <= err_cnt_q + 5'd1;
                    end
`endif
                    // drv_in stops at LAST, so it never wraps
                    if (drv_q == LAST) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        drv_q   <= drv_q + 4'd1;
                        cnt_q   <= '0;
                        state_q <= DRIVE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus_io.drv_in    = drv_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.done      = done_q;
    assign bus_io.cap_valid = valid_q;
    assign bus_io.cap_code  = code_q;
    assign bus_io.cap_data  = data_q;
    assign bus_io.sig       = sig_q;
endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// tb_comb_sweep_ctrl: self-checking bench for comb_sweep_ctrl (default and single-code instances)
module tb_comb_sweep_ctrl;
    localparam int S = 2;
    typedef struct {
        logic [3:0] code;
        logic [4:0] data;
    } vec_t;
    typedef struct {
        int mode;
        bit keep;
        bit flt;
        int done_cyc;
    } scen_t;
    logic  clk = 1'b0;
    logic  rst_n;
    logic  fault;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    pulses = 0;
    vec_t  tab [16];
    scen_t sc [$];
    comb_sweep_ctrl_if b1 ();
    comb_sweep_ctrl_if b2 ();
    comb_sweep_ctrl #(.SETTLE(S), .FIRST(4'd0), .LAST(4'd15)) dut (.clk(clk), .rst_n(rst_n), .bus_io(b1));
    comb_sweep_ctrl #(.SETTLE(S), .FIRST(4'd5), .LAST(4'd5)) dut2 (.clk(clk), .rst_n(rst_n), .bus_io(b2));
    always #5 clk = ~clk;
    function automatic logic [4:0] gold(input logic [3:0] x);
        return {x[3] | (x[2] & x[1]),
                (~x[3] & ~x[1]) | (~x[3] & ~x[2]) | (x[3] & x[2] & x[1]),
                x[2] ^ x[1], ~x[1], x[0]};
    endfunction
    assign b1.dut_out = gold(b1.drv_in) & ~{4'b0000, fault};
    assign b2.dut_out = gold(b2.drv_in);
    always @(negedge clk) if (b1.cap_valid === 1'b1) pulses++;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // one sweep of the default instance; the bench walks the sweep rules procedurally
    task automatic sweep(input int mode, input bit keep, input bit flt, input int exp_done);
        logic [7:0] s;
        logic [4:0] d;
        int cyc, extra, errs, p0, n, hc;
        bit h;
        fault = flt;
        s = '0; cyc = 1; extra = 0; errs = 0; p0 = pulses;
        b1.start = 1'b1;
        @(negedge clk);
        if (!keep) b1.start = 1'b0;
        chk("start_busy", b1.busy, 1);
        chk("start_sig", b1.sig, 0);
`ifdef SWEEP_CHECK_EN
        chk("start_err_cnt", b1.err_cnt, 0);
`endif
        for (int c = 0; c < 16; c++) begin
            chk("drv_in", b1.drv_in, tab[c].code);
            n = 0; hc = 0;
            while (n < S) begin
                h = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 2 && c == 3 && hc < 5);
                if (h) begin hc++; extra++; end
                b1.hold = h;
                if (mode == 3 && c == 8) b1.start = 1'b1;
                @(negedge clk);
                cyc++;
                if (!h) n++;
            end
            b1.hold = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!keep) b1.start = 1'b0;
            @(negedge clk);
            cyc++;
            d = tab[c].data & ~{4'b0000, flt};
            if (d != tab[c].data) errs++;
            s = {s[6:0], s[7]} ^ {3'b000, d};
            chk("cap_valid", b1.cap_valid, 1);
            chk("cap_code", b1.cap_code, tab[c].code);
            chk("cap_data", b1.cap_data, d);
            chk("sig", b1.sig, s);
        end
        chk("done", b1.done, 1);
        chk("done_cycle", cyc, exp_done + ((mode == 1) ? extra : 0));
`ifdef SWEEP_CHECK_EN
        chk("err_cnt", b1.err_cnt, (errs > 31) ? 31 : errs);
        chk("err_flag", b1.err_flag, errs != 0);
`endif
        b1.hold = 1'b0;
        @(negedge clk);
        chk("idle_done", b1.done, 0);
        chk("idle_busy", b1.busy, 0);
        chk("idle_sig", b1.sig, s);
        chk("idle_drv_in", b1.drv_in, 15);
        chk("pulse_count", pulses - p0, 16);
    endtask
    initial begin
        int k;
        tab = '{'{4'd0, 5'b01010}, '{4'd1, 5'b01011}, '{4'd2, 5'b01100}, '{4'd3, 5'b01101},
                '{4'd4, 5'b01110}, '{4'd5, 5'b01111}, '{4'd6, 5'b10000}, '{4'd7, 5'b10001},
                '{4'd8, 5'b10010}, '{4'd9, 5'b10011}, '{4'd10, 5'b10100}, '{4'd11, 5'b10101},
                '{4'd12, 5'b10110}, '{4'd13, 5'b10111}, '{4'd14, 5'b11000}, '{4'd15, 5'b11001}};
        sc.push_back('{0, 1'b0, 1'b0, 49});
        sc.push_back('{2, 1'b0, 1'b0, 54});
        sc.push_back('{1, 1'b0, 1'b0, 49});
        sc.push_back('{3, 1'b0, 1'b0, 49});
        sc.push_back('{0, 1'b1, 1'b0, 49});
        sc.push_back('{0, 1'b1, 1'b0, 49});
        sc.push_back('{1, 1'b0, 1'b0, 49});
`ifdef SWEEP_CHECK_EN
        sc.push_back('{0, 1'b0, 1'b1, 49});
        sc.push_back('{0, 1'b0, 1'b0, 49});
`endif
        b1.start = 1'b0; b1.hold = 1'b0; b2.start = 1'b0; b2.hold = 1'b0;
        fault = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", b1.busy, 0);
        chk("rst_done", b1.done, 0);
        chk("rst_drv_in", b1.drv_in, 0);
        chk("rst_cap", {b1.cap_valid, b1.cap_code, b1.cap_data}, 0);
        chk("rst_sig", b1.sig, 0);
        chk("rst2_outs", {b2.busy, b2.done, b2.drv_in, b2.sig}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        foreach (sc[i]) sweep(sc[i].mode, sc[i].keep, sc[i].flt, sc[i].done_cyc);
        // abort mid-sweep with an asynchronous reset during code 7
        fault = 1'b0;
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        k = 0;
        while (!(b1.drv_in == 4'd7 && b1.busy) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("reach_code7", k < 100, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", {b1.busy, b1.done, b1.cap_valid, b1.drv_in, b1.cap_code, b1.cap_data, b1.sig}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_done", {b1.done, b1.busy}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        sweep(0, 1'b0, 1'b0, 49);
        // single-code instance: FIRST=LAST=5
        b2.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        chk("one_drv_in", b2.drv_in, 5);
        chk("one_busy", b2.busy, 1);
        repeat (2) @(negedge clk);
        chk("one_no_cap_yet", {b2.cap_valid, b2.done}, 0);
        @(negedge clk);
        chk("one_done", b2.done, 1);
        chk("one_cap_valid", b2.cap_valid, 1);
        chk("one_cap_code", b2.cap_code, 5);
        chk("one_cap_data", b2.cap_data, tab[5].data);
        chk("one_sig", b2.sig, {3'b000, tab[5].data});
        @(negedge clk);
        chk("one_idle", {b2.done, b2.busy, b2.cap_valid}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
